// File: rtl/uart_loader.sv
// 8N1 serial bootloader: sync A5, 16-bit word count, little-endian words written to instruction memory.
// Writes hold until mem_ready; a byte arriving mid-write aborts. Checksum byte when UART_LOADER_CKSUM_EN is defined.
module uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_in,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int unsigned   CW      = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [7:0]    SYNC    = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_state;
   logic          s_meta, s_sync, s_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          byte_stb, frame_err;

   // rx_shift stays valid during byte_stb: the next frame cannot shift in before a full bit time
   always_ff @(posedge clk) begin
      if (!rst) begin
         s_meta    <= 1'b1;
         s_sync    <= 1'b1;
         s_prev    <= 1'b1;
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s_meta    <= s_in;
         s_sync    <= s_meta;
         s_prev    <= s_sync;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (s_prev && !s_sync) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_M1) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= s_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == FULL_M1) begin
                  rx_cnt   <= '0;
                  rx_shift <= {s_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == FULL_M1) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
                  if (s_sync) byte_stb  <= 1'b1;
                  else        frame_err <= 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE,
`ifdef UART_LOADER_CKSUM_EN
      CKSUM,
`endif
      DONE, ERR} state_t;

`ifdef UART_LOADER_CKSUM_EN
   localparam state_t END_ST = CKSUM;
`else
   localparam state_t END_ST = DONE;
`endif

   state_t      state;
   logic [15:0] len, idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_lo;
   logic [7:0]  cksum;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         len       <= '0;
         idx       <= '0;
         byte_cnt  <= '0;
         word_lo   <= '0;
         cksum     <= '0;
         mem_wr_en <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (byte_stb && rx_shift == SYNC) begin
                  state    <= LEN0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  idx      <= '0;
                  byte_cnt <= '0;
                  cksum    <= '0;
               end
            end
            LEN0: begin
               if (frame_err) state <= ERR;
               else if (byte_stb) begin
                  len[7:0] <= rx_shift;
                  state    <= LEN1;
               end
            end
            LEN1: begin
               if (frame_err) state <= ERR;
               else if (byte_stb) begin
                  len[15:8] <= rx_shift;
                  state     <= ({rx_shift, len[7:0]} == 16'd0) ? END_ST : DATA;
               end
            end
            DATA: begin
               if (frame_err) state <= ERR;
               else if (byte_stb) begin
                  cksum    <= cksum ^ rx_shift;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) begin
                     state     <= WRITE;
                     mem_wr_en <= 1'b1;
                     mem_addr  <= BASE_ADDR + {14'd0, idx, 2'b00};
                     mem_wdata <= {rx_shift, word_lo};
                  end else begin
                     word_lo[{byte_cnt, 3'b000} +: 8] <= rx_shift;
                  end
               end
            end
            WRITE: begin
               // any byte finishing here means the sender outran the memory
               if (frame_err || byte_stb) begin
                  mem_wr_en <= 1'b0;
                  state     <= ERR;
               end else if (mem_ready) begin
                  mem_wr_en <= 1'b0;
                  idx       <= idx + 16'd1;
                  state     <= (idx == len - 16'd1) ? END_ST : DATA;
               end
            end
`ifdef UART_LOADER_CKSUM_EN
            CKSUM: begin
               if (frame_err) state <= ERR;
               else if (byte_stb) state <= (rx_shift == cksum) ? DONE : ERR;
            end
`endif
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERR: begin
               err       <= 1'b1;
               busy      <= 1'b0;
               mem_wr_en <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised and directed bench for uart_loader against a protocol-level reference model.
`timescale 1ns/1ps
module tb_uart_loader;
   localparam int CPB = 16;
`ifdef UART_LOADER_CKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clk = 1'b0, rst = 1'b0, s_in = 1'b1, mem_ready = 1'b0;
   logic        mem_wr_en, busy, done, err;
   logic [31:0] mem_addr, mem_wdata;

   int tests = 0, fails = 0;
   int ready_delay = 0;
   int unstable = 0;
   int hold = 0;
   logic [31:0] hold_addr, hold_data;
   logic [31:0] wr_addr_q[$], wr_data_q[$];
   int          wr_len_q[$];
   logic [7:0]  stim_b[$];
   bit          stim_ok[$];
   logic [31:0] exp_addr[$], exp_data[$];
   bit          exp_done, exp_err;

   uart_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .s_in(s_in), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // memory model: accepts after ready_delay wait cycles, logs each accepted write
   always @(negedge clk) begin
      if (!mem_wr_en) begin
         hold = 0;
         mem_ready = 1'b0;
      end else begin
         if (hold == 0) begin
            hold_addr = mem_addr;
            hold_data = mem_wdata;
         end else if (mem_addr !== hold_addr || mem_wdata !== hold_data) begin
            unstable++;
         end
         mem_ready = (hold >= ready_delay);
         hold++;
         if (mem_ready) begin
            wr_addr_q.push_back(hold_addr);
            wr_data_q.push_back(hold_data);
            wr_len_q.push_back(hold);
         end
      end
   end

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic clr();
      stim_b.delete(); stim_ok.delete();
      wr_addr_q.delete(); wr_data_q.delete(); wr_len_q.delete();
      unstable = 0;
   endtask

   task automatic add(input logic [7:0] b, input bit ok);
      stim_b.push_back(b);
      stim_ok.push_back(ok);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      s_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         s_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      s_in = ok;
      repeat (CPB) @(negedge clk);
      s_in = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_stream();
      foreach (stim_b[i]) begin
         send_byte(stim_b[i], stim_ok[i]);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      repeat (2 * CPB) @(negedge clk);
   endtask

   // Protocol-level view: first good A5 starts a load; word count, words, optional checksum.
   task automatic run_model(input bit pdone, input bit perr);
      int s, n, f, L, need;
      logic [7:0] body[$];
      logic [7:0] x;
      exp_addr.delete(); exp_data.delete();
      exp_done = pdone; exp_err = perr;
      s = -1;
      foreach (stim_b[i]) if (s < 0 && stim_ok[i] && stim_b[i] == 8'hA5) s = i;
      if (s < 0) return;
      exp_done = 0; exp_err = 0;
      f = -1;
      for (int i = s + 1; i < stim_b.size(); i++) begin
         body.push_back(stim_b[i]);
         if (f < 0 && !stim_ok[i]) f = i - s - 1;
      end
      n = body.size();
      if (f < 0) f = n;
      if (f < 2) begin exp_err = (f < n); return; end
      L = int'({body[1], body[0]});
      need = 2 + 4 * L + CK;
      x = 8'h00;
      for (int k = 0; k < L; k++) begin
         if (2 + 4 * k + 3 >= f) break;
         exp_addr.push_back(32'(4 * k));
         exp_data.push_back({body[5 + 4 * k], body[4 + 4 * k], body[3 + 4 * k], body[2 + 4 * k]});
         x = x ^ body[2 + 4 * k] ^ body[3 + 4 * k] ^ body[4 + 4 * k] ^ body[5 + 4 * k];
      end
      if (f < need) exp_err = (f < n);
      else if (CK == 1) begin
         exp_done = (body[2 + 4 * L] == x);
         exp_err  = !exp_done;
      end else exp_done = 1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_word();
      clr(); ready_delay = 0;
      add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
      add(8'h78, 1); add(8'h56, 1); add(8'h34, 1); add(8'h12, 1);
      if (CK == 1) add(8'h08, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d want 1", wr_addr_q.size()); end
      tests++; if (qat(wr_addr_q, 0) !== 32'h0) begin fails++; $display("FAIL single_addr: got %h want 00000000", qat(wr_addr_q, 0)); end
      tests++; if (qat(wr_data_q, 0) !== 32'h1234_5678) begin fails++; $display("FAIL single_data: got %h want 12345678", qat(wr_data_q, 0)); end
      tests++; if ({done, err, busy} !== 3'b100) begin fails++; $display("FAIL single_flags: got done/err/busy %b want 100", {done, err, busy}); end
   endtask

   task automatic test_sync_as_data();
      clr(); ready_delay = 1;
      add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
      repeat (4) add(8'hA5, 1);
      if (CK == 1) add(8'h00, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 1 || qat(wr_data_q, 0) !== 32'hA5A5_A5A5) begin
         fails++; $display("FAIL sync_data: got %0d writes data %h want 1 write A5A5A5A5", wr_addr_q.size(), qat(wr_data_q, 0)); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL sync_done: got %b want 1", done); end
   endtask

   task automatic test_zero_len();
      clr(); ready_delay = 0;
      add(8'hA5, 1); add(8'h00, 1); add(8'h00, 1);
      if (CK == 1) add(8'h00, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL zero_count: got %0d want 0", wr_addr_q.size()); end
      tests++; if ({done, err, busy} !== 3'b100) begin fails++; $display("FAIL zero_flags: got done/err/busy %b want 100", {done, err, busy}); end
   endtask

   task automatic test_glitch();
      clr(); ready_delay = 0;
      s_in = 1'b0;
      @(negedge clk);
      s_in = 1'b1;
      repeat (20) @(negedge clk);
      add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
      add(8'hDE, 1); add(8'hAD, 1); add(8'hBE, 1); add(8'hEF, 1);
      if (CK == 1) add(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 1 || qat(wr_data_q, 0) !== 32'hEFBE_ADDE) begin
         fails++; $display("FAIL glitch_load: got %0d writes data %h want 1 write EFBEADDE", wr_addr_q.size(), qat(wr_data_q, 0)); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL glitch_done: got %b want 1", done); end
   endtask

   task automatic test_backpressure();
      clr(); ready_delay = 20;
      add(8'hA5, 1); add(8'h02, 1); add(8'h00, 1);
      add(8'h11, 1); add(8'h22, 1); add(8'h33, 1); add(8'h44, 1);
      add(8'h55, 1); add(8'h66, 1); add(8'h77, 1); add(8'h88, 1);
      if (CK == 1) add(8'h88, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 2) begin fails++; $display("FAIL bp_count: got %0d want 2", wr_addr_q.size()); end
      for (int i = 0; i < 2; i++) begin
         tests++; if (i >= wr_len_q.size() || wr_len_q[i] !== 21) begin
            fails++; $display("FAIL bp_len%0d: got %0d want 21", i, (i < wr_len_q.size()) ? wr_len_q[i] : -1); end
      end
      tests++; if (qat(wr_addr_q, 0) !== 32'h0 || qat(wr_addr_q, 1) !== 32'h4) begin
         fails++; $display("FAIL bp_addr: got %h %h want 00000000 00000004", qat(wr_addr_q, 0), qat(wr_addr_q, 1)); end
      tests++; if (qat(wr_data_q, 0) !== 32'h4433_2211 || qat(wr_data_q, 1) !== 32'h8877_6655) begin
         fails++; $display("FAIL bp_data: got %h %h want 44332211 88776655", qat(wr_data_q, 0), qat(wr_data_q, 1)); end
      tests++; if (unstable !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done: got %b want 1", done); end
      ready_delay = 0;
   endtask

   task automatic test_reset_mid();
      clr(); ready_delay = 0;
      add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1); add(8'h78, 1); add(8'h56, 1);
      send_stream();
      rst = 1'b0;
      @(negedge clk);
      tests++; if ({mem_wr_en, busy, done, err} !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         fails++; $display("FAIL rstmid_outputs: got wr/busy/done/err %b addr %h data %h want all 0",
                           {mem_wr_en, busy, done, err}, mem_addr, mem_wdata); end
      rst = 1'b1;
      clr();
      add(8'h78, 1); add(8'h56, 1); add(8'h34, 1); add(8'h12, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL rstmid_nowrite: got %0d writes want 0", wr_addr_q.size()); end
      tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL rstmid_flags: got busy/done/err %b want 000", {busy, done, err}); end
   endtask

   task automatic test_framing();
      clr(); ready_delay = 0;
      add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1); add(8'h78, 1); add(8'h56, 0);
      send_stream();
      tests++; if ({err, busy, done} !== 3'b100) begin fails++; $display("FAIL frame_flags: got err/busy/done %b want 100", {err, busy, done}); end
      clr();
      add(8'h34, 1); add(8'h12, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL frame_nowrite: got %0d writes want 0", wr_addr_q.size()); end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL frame_sticky: got %b want 1", err); end
   endtask

`ifdef UART_LOADER_CKSUM_EN
   task automatic test_cksum_bad();
      clr(); ready_delay = 0;
      add(8'hA5, 1); add(8'h01, 1); add(8'h00, 1);
      add(8'h78, 1); add(8'h56, 1); add(8'h34, 1); add(8'h12, 1); add(8'h00, 1);
      send_stream();
      tests++; if (wr_addr_q.size() !== 1 || qat(wr_data_q, 0) !== 32'h1234_5678) begin
         fails++; $display("FAIL ck_write: got %0d writes data %h want 1 write 12345678", wr_addr_q.size(), qat(wr_data_q, 0)); end
      tests++; if ({err, done} !== 2'b10) begin fails++; $display("FAIL ck_flags: got err/done %b want 10", {err, done}); end
   endtask
`endif

   task automatic test_overrun();
      clr(); ready_delay = 1000;
      add(8'hA5, 1); add(8'h02, 1); add(8'h00, 1);
      add(8'h01, 1); add(8'h02, 1); add(8'h03, 1); add(8'h04, 1); add(8'h05, 1);
      send_stream();
      tests++; if ({err, busy, mem_wr_en} !== 3'b100) begin fails++; $display("FAIL overrun_flags: got err/busy/wr_en %b want 100", {err, busy, mem_wr_en}); end
      tests++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL overrun_nowrite: got %0d writes want 0", wr_addr_q.size()); end
      ready_delay = 0;
   endtask

   task automatic test_random();
      int nj, L, bad;
      logic [7:0] b, x;
      for (int it = 0; it < 8; it++) begin
         clr();
         ready_delay = $urandom_range(0, 5);
         nj = $urandom_range(0, 2);
         for (int j = 0; j < nj; j++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            add(b, $urandom_range(0, 3) != 0);
         end
         add(8'hA5, 1);
         L = $urandom_range(1, 3);
         add(L[7:0], 1); add(8'h00, 1);
         x = 8'h00;
         for (int j = 0; j < 4 * L; j++) begin
            b = 8'($urandom);
            x = x ^ b;
            add(b, 1);
         end
         if (CK == 1) add(($urandom_range(0, 3) == 0) ? ~x : x, 1);
         if ($urandom_range(0, 3) == 0) begin
            bad = $urandom_range(nj + 1, stim_b.size() - 1);
            stim_ok[bad] = 1'b0;
         end
         run_model(done, err);
         send_stream();
         tests++; if (wr_addr_q.size() !== exp_addr.size()) begin
            fails++; $display("FAIL rand%0d_count: got %0d want %0d", it, wr_addr_q.size(), exp_addr.size()); end
         for (int k = 0; k < exp_addr.size(); k++) begin
            tests++; if (qat(wr_addr_q, k) !== exp_addr[k] || qat(wr_data_q, k) !== exp_data[k]) begin
               fails++; $display("FAIL rand%0d_word%0d: got %h/%h want %h/%h", it, k,
                                 qat(wr_addr_q, k), qat(wr_data_q, k), exp_addr[k], exp_data[k]); end
         end
         tests++; if ({done, err} !== {exp_done, exp_err}) begin
            fails++; $display("FAIL rand%0d_flags: got done/err %b want %b", it, {done, err}, {exp_done, exp_err}); end
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rand%0d_busy: got %b want 0", it, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_sync_as_data();
      test_zero_len();
      test_glitch();
      test_backpressure();
      test_reset_mid();
      test_framing();
`ifdef UART_LOADER_CKSUM_EN
      test_cksum_bad();
`endif
      test_overrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
